exe_stage: RTL



---
 rtl/exe_stage_if.sv | 48 ++++
 rtl/exe_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_if.sv
// Execute-stage pipeline bundle: decode handshake, memory handshake, data-SRAM request
// and the forwarding/stall bus back to decode.
interface exe_stage_if;
    localparam int DS_TO_ES_BUS_WD = 152;
    localparam int ES_TO_MS_BUS_WD = 71;

    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_wen;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;
    logic [37:0]                stuck_es_to_ds_bus;

    // The execute stage itself
    modport master (
        input  ms_allowin,
        input  ds_to_es_valid,
        input  ds_to_es_bus,
        output es_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        output stuck_es_to_ds_bus
    );

    // The surrounding pipeline (decode, memory stage, data SRAM)
    modport slave (
        output ms_allowin,
        output ds_to_es_valid,
        output ds_to_es_bus,
        input  es_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  stuck_es_to_ds_bus
    );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, MFHI/MFLO, data-SRAM request and forwarding bus to decode.
// Define ES_DIV_EN to build the iterative div/divu unit that writes HI/LO.
module exe_stage (
    input  logic        clk,
    input  logic        resetn,
    exe_stage_if.master pipe
);
    localparam int DS_TO_ES_BUS_WD = 152;

    logic                       es_valid_r;
    logic [DS_TO_ES_BUS_WD-1:0] ds_bus_r;
    logic                       es_ready_go_s;
    logic                       es_allowin_s;

    logic [11:0] alu_op_s;
    logic [3:0]  hilo_op_s;
    logic        res_from_mem_s;
    logic        gr_we_s;
    logic        mem_we_s;
    logic [4:0]  dest_s;
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [31:0] st_data_s;
    logic [31:0] pc_s;

    logic [4:0]  shamt_s;
    logic [31:0] add_res_s;
    logic [31:0] sub_res_s;
    logic [31:0] slt_res_s;
    logic [31:0] sltu_res_s;
    logic [31:0] sll_res_s;
    logic [31:0] srl_res_s;
    logic [31:0] sra_res_s;
    logic [31:0] lui_res_s;
    logic [31:0] alu_result_s;
    logic [31:0] es_result_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        sram_en_s;

    assign {alu_op_s, hilo_op_s, res_from_mem_s, gr_we_s, mem_we_s, dest_s,
            src1_s, src2_s, st_data_s, pc_s} = ds_bus_r;

    assign es_allowin_s        = !es_valid_r || (es_ready_go_s && pipe.ms_allowin);
    assign pipe.es_allowin     = es_allowin_s;
    assign pipe.es_to_ms_valid = es_valid_r && es_ready_go_s;

    // Stage occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_r <= 1'b0;
        end else if (es_allowin_s) begin
            es_valid_r <= pipe.ds_to_es_valid;
        end else begin
            es_valid_r <= es_valid_r;
        end
    end

    // Decoded-instruction register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_bus_r <= 152'h0;
        end else if (pipe.ds_to_es_valid && es_allowin_s) begin
            ds_bus_r <= pipe.ds_to_es_bus;
        end else begin
            ds_bus_r <= ds_bus_r;
        end
    end

    // Shifts take the amount from src1 and the value from src2.
    assign shamt_s    = src1_s[4:0];
    assign add_res_s  = src1_s + src2_s;
    assign sub_res_s  = src1_s - src2_s;
    assign slt_res_s  = {31'h0, ($signed(src1_s) < $signed(src2_s))};
    assign sltu_res_s = {31'h0, (src1_s < src2_s)};
    assign sll_res_s  = src2_s << shamt_s;
    assign srl_res_s  = src2_s >> shamt_s;
    assign sra_res_s  = $unsigned($signed(src2_s) >>> shamt_s);
    assign lui_res_s  = {src2_s[15:0], 16'h0};

    // alu_op is one-hot; an instruction with no ALU op yields zero.
    assign alu_result_s = ({32{alu_op_s[0]}}  & add_res_s)
                        | ({32{alu_op_s[1]}}  & sub_res_s)
                        | ({32{alu_op_s[2]}}  & slt_res_s)
                        | ({32{alu_op_s[3]}}  & sltu_res_s)
                        | ({32{alu_op_s[4]}}  & (src1_s & src2_s))
                        | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s))
                        | ({32{alu_op_s[6]}}  & (src1_s | src2_s))
                        | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s))
                        | ({32{alu_op_s[8]}}  & sll_res_s)
                        | ({32{alu_op_s[9]}}  & srl_res_s)
                        | ({32{alu_op_s[10]}} & sra_res_s)
                        | ({32{alu_op_s[11]}} & lui_res_s);

    // Result select: MFHI / MFLO override the ALU
    always_comb begin
        if (hilo_op_s[2]) begin
            es_result_s = hi_s;
        end else if (hilo_op_s[3]) begin
            es_result_s = lo_s;
        end else begin
            es_result_s = alu_result_s;
        end
    end

`ifdef ES_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    div_state_e  state_r;
    div_state_e  state_s;
    logic        is_div_s;
    logic        div_signed_s;
    logic        div_leave_s;
    logic [31:0] abs_src1_s;
    logic [31:0] abs_src2_s;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [4:0]  count_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic [32:0] partial_s;
    logic [32:0] trial_s;
    logic [31:0] step_quo_s;
    logic [31:0] step_rem_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    assign is_div_s      = es_valid_r && (hilo_op_s[0] || hilo_op_s[1]);
    assign div_signed_s  = hilo_op_s[0];
    assign es_ready_go_s = !(is_div_s && (state_r != DIV_DONE));
    assign div_leave_s   = (state_r == DIV_DONE) && es_ready_go_s && pipe.ms_allowin;
    assign abs_src1_s    = (div_signed_s && src1_s[31]) ? (32'h0 - src1_s) : src1_s;
    assign abs_src2_s    = (div_signed_s && src2_s[31]) ? (32'h0 - src2_s) : src2_s;
    assign hi_s          = hi_r;
    assign lo_s          = lo_r;

    // Divider state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Divider next state
    always_comb begin
        state_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (is_div_s && (src2_s == 32'h0)) begin
                    state_s = DIV_DONE;
                end else if (is_div_s) begin
                    state_s = DIV_BUSY;
                end else begin
                    state_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (count_r == 5'd31) begin
                    state_s = DIV_DONE;
                end else begin
                    state_s = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                if (div_leave_s) begin
                    state_s = DIV_IDLE;
                end else begin
                    state_s = DIV_DONE;
                end
            end
            default: state_s = DIV_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    // The remainder stays below the divisor, so 33 bits cover the trial.
    always_comb begin
        partial_s = {rem_r, quo_r[31]};
        trial_s   = partial_s - {1'b0, dvs_r};
        if (trial_s[32]) begin
            step_rem_s = partial_s[31:0];
            step_quo_s = {quo_r[30:0], 1'b0};
        end else begin
            step_rem_s = trial_s[31:0];
            step_quo_s = {quo_r[30:0], 1'b1};
        end
    end

    // Divider datapath; quo_r/rem_r hold the final LO/HI values while in DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_r   <= 32'h0;
            rem_r   <= 32'h0;
            dvs_r   <= 32'h0;
            count_r <= 5'd0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (is_div_s && (src2_s == 32'h0)) begin
                        quo_r <= 32'hFFFF_FFFF;
                        rem_r <= src1_s;
                    end else if (is_div_s) begin
                        quo_r   <= abs_src1_s;
                        rem_r   <= 32'h0;
                        dvs_r   <= abs_src2_s;
                        count_r <= 5'd0;
                        q_neg_r <= div_signed_s && (src1_s[31] ^ src2_s[31]);
                        r_neg_r <= div_signed_s && src1_s[31];
                    end
                end
                DIV_BUSY: begin
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        quo_r <= q_neg_r ? (32'h0 - step_quo_s) : step_quo_s;
                        rem_r <= r_neg_r ? (32'h0 - step_rem_s) : step_rem_s;
                    end else begin
                        quo_r <= step_quo_s;
                        rem_r <= step_rem_s;
                    end
                end
                default: begin
                    quo_r <= quo_r;
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    // HI/LO commit only as the divide leaves ES, so a trailing MFHI/MFLO needs no interlock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= 32'h0;
            lo_r <= 32'h0;
        end else if (div_leave_s) begin
            hi_r <= rem_r;
            lo_r <= quo_r;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end
`else
    logic div_unused_s;

    assign es_ready_go_s = 1'b1;
    assign hi_s          = 32'h0;
    assign lo_s          = 32'h0;
    assign div_unused_s  = ^hilo_op_s[1:0];
`endif

    assign pipe.es_to_ms_bus = {res_from_mem_s, gr_we_s, dest_s, es_result_s, pc_s};

    // A request only goes out in the cycle MS accepts, so a stalled store is not repeated.
    assign sram_en_s            = es_valid_r && pipe.ms_allowin && (res_from_mem_s || mem_we_s);
    assign pipe.data_sram_en    = sram_en_s;
    assign pipe.data_sram_wen   = {4{sram_en_s && mem_we_s}};
    assign pipe.data_sram_addr  = alu_result_s;
    assign pipe.data_sram_wdata = st_data_s;

    assign pipe.stuck_es_to_ds_bus = (es_valid_r && gr_we_s)
                                   ? {res_from_mem_s, dest_s, es_result_s}
                                   : 38'h0;
endmodule
